// File: rtl/risc_seq_ctrl_if.sv
// risc_seq_ctrl_if: sequencer <-> datapath/data-memory control bundle
// master = sequencer (samples run/opcode/mem_ready, drives all controls)
// slave  = datapath side (mirror image)
interface risc_seq_ctrl_if #(parameter int CNT_W = 16);
  logic run;
  logic [3:0] opcode;
  logic mem_ready;
  logic pc_en, jump, beq, bne;
  logic mem_read, mem_write, mem_req;
  logic alu_src, reg_dst, mem_to_reg, reg_write;
  logic [1:0] alu_op;
  logic busy, illegal;
  logic [CNT_W-1:0] retired;
  modport master (
    input  run, opcode, mem_ready,
    output pc_en, jump, beq, bne, mem_read, mem_write, mem_req,
           alu_src, reg_dst, mem_to_reg, reg_write, alu_op, busy, illegal, retired
  );
  modport slave (
    output run, opcode, mem_ready,
    input  pc_en, jump, beq, bne, mem_read, mem_write, mem_req,
           alu_src, reg_dst, mem_to_reg, reg_write, alu_op, busy, illegal, retired
  );
endinterface

// File: rtl/risc_seq_ctrl.sv
// risc_seq_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer
// clk, rst_n (async active-low); bus: risc_seq_ctrl_if.master carrying
// run/opcode/mem_ready in and PC, memory, datapath controls, busy, illegal, retired out
module risc_seq_ctrl #(parameter int CNT_W = 16) (
  input logic clk,
  input logic rst_n,
  risc_seq_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB} state_t;
  typedef enum logic [2:0] {C_LD, C_ST, C_R, C_BEQ, C_BNE, C_J, C_NOP} cls_t;
  state_t state, nxt;
  cls_t cls, dec;
  logic commit, steer, illegal_q;
  logic [CNT_W-1:0] retired_q;
  always_comb
    dec = bus.opcode == 4'd0  ? C_LD  :
          bus.opcode == 4'd1  ? C_ST  :
          bus.opcode <= 4'd9  ? C_R   :
          bus.opcode == 4'd11 ? C_BEQ :
          bus.opcode == 4'd12 ? C_BNE :
          bus.opcode == 4'd13 ? C_J   : C_NOP;
  // the single cycle per instruction in which architectural state changes
  assign commit = (state == EXEC && !(cls inside {C_LD, C_ST})) ||
                  (state == MEM && cls == C_ST && bus.mem_ready) ||
                  state == WB;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = (commit || state == IDLE) ? (bus.run ? FETCH : IDLE) :
          state == FETCH  ? DECODE :
          state == DECODE ? EXEC   :
          state == EXEC   ? MEM    :
          state == MEM    ? (bus.mem_ready ? WB : MEM) : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cls <= C_NOP;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      if (state == FETCH) cls <= dec;
      if (state == FETCH && dec == C_NOP) illegal_q <= 1'b1;
      if (commit) retired_q <= retired_q + 1'b1;
    end
  // steering is only meaningful once the class has been latched
  assign steer = !(state inside {IDLE, FETCH});
  always_comb begin
    bus.pc_en      = commit;
    bus.reg_write  = commit && cls inside {C_LD, C_R};
    bus.mem_write  = commit && cls == C_ST;
    bus.jump       = commit && cls == C_J;
    bus.beq        = commit && cls == C_BEQ;
    bus.bne        = commit && cls == C_BNE;
    bus.mem_req    = state == MEM;
    bus.mem_read   = steer && cls == C_LD;
    bus.alu_src    = steer && cls inside {C_LD, C_ST};
    bus.reg_dst    = steer && cls == C_R;
    bus.mem_to_reg = steer && cls == C_LD;
    bus.alu_op     = !steer ? 2'b00 :
                     cls inside {C_LD, C_ST}   ? 2'b10 :
                     cls inside {C_BEQ, C_BNE} ? 2'b01 : 2'b00;
    bus.busy       = state != IDLE;
    bus.illegal    = illegal_q;
    bus.retired    = retired_q;
  end
endmodule

// File: tb/tb_risc_seq_ctrl.sv
// tb_risc_seq_ctrl: directed self-checking bench for risc_seq_ctrl
module tb_risc_seq_ctrl;
  localparam int CW = 8;
  localparam logic [14:0] PC = 15'h4000, JMP = 15'h2000, BQ = 15'h1000, BN = 15'h0800,
                          MR = 15'h0400, MW = 15'h0200, MQ = 15'h0100, AS = 15'h0080,
                          RD = 15'h0040, MTR = 15'h0020, RW = 15'h0010, AO1 = 15'h0008,
                          AO0 = 15'h0004, BSY = 15'h0002, ILL = 15'h0001;
  localparam logic [14:0] LDS = AS | MTR | MR | AO1;
  localparam logic [14:0] STS = AS | AO1;
  logic clk = 1'b0;
  logic rst_n;
  int tests = 0, fails = 0;
  risc_seq_ctrl_if #(.CNT_W(CW)) b ();
  risc_seq_ctrl #(.CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  always #5 clk = ~clk;
  logic [14:0] ctl;
  assign ctl = {b.pc_en, b.jump, b.beq, b.bne, b.mem_read, b.mem_write, b.mem_req,
                b.alu_src, b.reg_dst, b.mem_to_reg, b.reg_write, b.alu_op, b.busy, b.illegal};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic step(input string tag, input logic [14:0] e);
    tick();
    #1;
    chk(tag, {17'd0, ctl}, {17'd0, e});
  endtask
  initial begin
    b.run = 0; b.opcode = 4'd0; b.mem_ready = 0; rst_n = 1;
    #1 rst_n = 0;
    #1;
    chk("rst_ctl", {17'd0, ctl}, 0);
    chk("rst_ret", {24'd0, b.retired}, 0);
    step("rst_hold", 15'd0);
    @(negedge clk);
    rst_n = 1; b.run = 1; b.opcode = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      step("r_fetch", BSY);
      step("r_dec", RD | BSY);
      step("r_exec", PC | RD | RW | BSY);
    end
    step("r_fetch5", BSY);
    chk("r_ret4", {24'd0, b.retired}, 4);
    b.opcode = 4'b0000;
    step("ld_dec", LDS | BSY);
    step("ld_exec", LDS | BSY);
    step("ld_mem1", LDS | MQ | BSY);
    step("ld_mem2", LDS | MQ | BSY);
    tick(); b.mem_ready = 1; #1;
    chk("ld_mem3", {17'd0, ctl}, {17'd0, LDS | MQ | BSY});
    tick(); b.mem_ready = 0; #1;
    chk("ld_wb", {17'd0, ctl}, {17'd0, PC | RW | LDS | BSY});
    step("st_fetch", BSY);
    chk("ld_ret5", {24'd0, b.retired}, 5);
    b.opcode = 4'b0001; b.mem_ready = 1;
    step("st_dec", STS | BSY);
    step("st_exec", STS | BSY);
    step("st_mem", PC | MW | MQ | STS | BSY);
    tick(); b.mem_ready = 0; #1;
    chk("beq_fetch", {17'd0, ctl}, {17'd0, BSY});
    chk("st_ret6", {24'd0, b.retired}, 6);
    b.opcode = 4'b1011;
    step("beq_dec", AO0 | BSY);
    step("beq_exec", PC | BQ | AO0 | BSY);
    step("bne_fetch", BSY);
    b.opcode = 4'b1100;
    step("bne_dec", AO0 | BSY);
    step("bne_exec", PC | BN | AO0 | BSY);
    step("j_fetch", BSY);
    b.opcode = 4'b1101;
    step("j_dec", BSY);
    step("j_exec", PC | JMP | BSY);
    step("nop_fetch", BSY);
    b.opcode = 4'b1111;
    step("nop_dec", BSY | ILL);
    step("nop_exec", PC | BSY | ILL);
    step("r2_fetch", BSY | ILL);
    b.opcode = 4'b0010;
    step("r2_dec", RD | BSY | ILL);
    step("r2_exec", PC | RD | RW | BSY | ILL);
    step("ld2_fetch", BSY | ILL);
    chk("ret11", {24'd0, b.retired}, 11);
    b.opcode = 4'b0000;
    step("ld2_dec", LDS | BSY | ILL);
    step("ld2_exec", LDS | BSY | ILL);
    tick(); b.run = 0; #1;
    chk("ld2_mem1", {17'd0, ctl}, {17'd0, LDS | MQ | BSY | ILL});
    tick(); b.mem_ready = 1; #1;
    chk("ld2_mem2", {17'd0, ctl}, {17'd0, LDS | MQ | BSY | ILL});
    tick(); b.mem_ready = 0; #1;
    chk("ld2_wb", {17'd0, ctl}, {17'd0, PC | RW | LDS | BSY | ILL});
    step("idle1", ILL);
    chk("ret12", {24'd0, b.retired}, 12);
    tick(); b.run = 1; #1;
    chk("idle2", {17'd0, ctl}, {17'd0, ILL});
    step("resume_fetch", BSY | ILL);
    b.opcode = 4'b0001;
    step("st2_dec", STS | BSY | ILL);
    step("st2_exec", STS | BSY | ILL);
    step("st2_mem", STS | MQ | BSY | ILL);
    rst_n = 0; b.mem_ready = 1; #1;
    chk("rst_mid_ctl", {17'd0, ctl}, 0);
    chk("rst_mid_ret", {24'd0, b.retired}, 0);
    step("rst_mid_hold", 15'd0);
    @(negedge clk);
    b.mem_ready = 0; b.opcode = 4'b1110; rst_n = 1;
    repeat (765) tick();
    step("wrap_fetch", BSY | ILL);
    chk("wrap_ret_max", {24'd0, b.retired}, 255);
    step("wrap_dec", BSY | ILL);
    step("wrap_exec", PC | BSY | ILL);
    chk("wrap_ret_hold", {24'd0, b.retired}, 255);
    step("wrap_fetch2", BSY | ILL);
    chk("wrap_ret_zero", {24'd0, b.retired}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
